// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared constants and types for the load/store unit
package mem_access_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_WRITE  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        ACCESS = ST_ACCESS,
        WRITE  = ST_WRITE,
        DONE   = ST_DONE
    } state_t;

    // Aligned word address holding the addressed byte
    function automatic logic [31:0] word_base(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/lane_mux.sv
// rtl/lane_mux.sv - sub-word load extraction/extension and store lane merge
module lane_mux
    import mem_access_pkg::*;
(
    input  logic [31:0] word,
    input  logic [15:0] wdata,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] load_data,
    output logic [31:0] store_data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Pick the addressed lane, extend it for loads, and splice new data in for stores
    always_comb begin
        byte_lane  = word[{lane, 3'b000} +: 8];
        half_lane  = word[{lane[1], 4'b0000} +: 16];
        load_data  = word;
        store_data = word;
        case (size)
            SIZE_BYTE: begin
                load_data = {{24{sign_ext & byte_lane[7]}}, byte_lane};
                store_data[{lane, 3'b000} +: 8] = wdata[7:0];
            end
            SIZE_HALF: begin
                load_data = {{16{sign_ext & half_lane[15]}}, half_lane};
                store_data[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: begin
                load_data  = word;
                store_data = word;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store initiator with sub-word RMW and fault checks
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 800
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [31:0] rdata,
    output logic [31:0] mem_address,
    output logic        mem_write_en,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    state_t      state;
    logic        we_q;
    logic [1:0]  size_q;
    logic        sign_ext_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] merge_q;
    logic        fault_q;

    logic [32:0] last_byte;
    logic        req_fault;
    logic [31:0] lane_word;
    logic [31:0] load_data;
    logic [31:0] store_data;

    // Fault decode on the incoming request; range check is 33 bits wide so it never wraps
    always_comb begin
        last_byte = {1'b0, word_base(addr)} + 33'd3;
        req_fault = 1'b0;
        if (size == 2'b11)                           req_fault = 1'b1;
        if (size == SIZE_HALF && addr[0])            req_fault = 1'b1;
        if (size == SIZE_WORD && addr[1:0] != 2'b00) req_fault = 1'b1;
        if (last_byte >= 33'(MEM_BYTES))             req_fault = 1'b1;
    end

    // Loads extract from live RAM data; the merge step works on the captured word
    assign lane_word = (state == WRITE) ? merge_q : mem_read_data;

    lane_mux u_lane_mux (
        .word       (lane_word),
        .wdata      (wdata_q[15:0]),
        .lane       (addr_q[1:0]),
        .size       (size_q),
        .sign_ext   (sign_ext_q),
        .load_data  (load_data),
        .store_data (store_data)
    );

    // Access sequencer: accept, read (and capture for RMW), write back, complete
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            size_q     <= SIZE_BYTE;
            sign_ext_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            merge_q    <= '0;
            fault_q    <= 1'b0;
            rdata      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        we_q       <= we;
                        size_q     <= size;
                        sign_ext_q <= sign_ext;
                        addr_q     <= addr;
                        wdata_q    <= wdata;
                        fault_q    <= req_fault;
                        state      <= req_fault ? DONE : ACCESS;
                    end
                end
                ACCESS: begin
                    if (!we_q) begin
                        rdata <= load_data;
                        state <= DONE;
                    end else if (size_q == SIZE_WORD) begin
                        state <= DONE;
                    end else begin
                        merge_q <= mem_read_data;
                        state   <= WRITE;
                    end
                end
                WRITE:   state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // RAM-side and status outputs decoded from the state register
    always_comb begin
        busy           = (state != IDLE);
        done           = (state == DONE);
        fault          = (state == DONE) & fault_q;
        mem_address    = '0;
        mem_write_en   = 1'b0;
        mem_write_data = '0;
        if (state == ACCESS) begin
            mem_address = word_base(addr_q);
            if (we_q && size_q == SIZE_WORD) begin
                mem_write_en   = !reset;
                mem_write_data = wdata_q;
            end
        end else if (state == WRITE) begin
            mem_address    = word_base(addr_q);
            mem_write_en   = !reset;
            mem_write_data = store_data;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit with a behavioural RAM
module tb_mem_access_unit;

    localparam int MEMB = 800;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        fault;
    logic [31:0] rdata;
    logic [31:0] mem_address;
    logic        mem_write_en;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    always #5 clk = ~clk;

    mem_access_unit #(.MEM_BYTES(MEMB)) dut (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
        .we             (we),
        .size           (size),
        .sign_ext       (sign_ext),
        .addr           (addr),
        .wdata          (wdata),
        .busy           (busy),
        .done           (done),
        .fault          (fault),
        .rdata          (rdata),
        .mem_address    (mem_address),
        .mem_write_en   (mem_write_en),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    typedef struct {
        logic        flt;
        logic [31:0] rd;
        int          lat;
        int          wrc;
        int          wro;
        int          icyc;
    } exp_t;

    exp_t        q[$];
    int          vec = 0;
    int          misc = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          wr_seen = 0;
    int          wr_last = 0;
    logic [7:0]  init_img [MEMB];
    logic [7:0]  ref_mem [MEMB];
    logic [7:0]  ram [MEMB];
    bit          ram_inited = 1'b0;
    logic [31:0] exp_rdata = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural RAM: combinational word read, synchronous word write
    always_comb begin
        mem_read_data = '0;
        if (mem_address <= 32'(MEMB - 4))
            for (int k = 0; k < 4; k++) mem_read_data[8*k +: 8] = ram[mem_address + 32'(k)];
    end

    always @(posedge clk) begin
        if (!ram_inited) begin
            for (int i = 0; i < MEMB; i++) ram[i] <= init_img[i];
            ram_inited <= 1'b1;
        end else if (mem_write_en && mem_address <= 32'(MEMB - 4)) begin
            for (int k = 0; k < 4; k++) ram[mem_address + 32'(k)] <= mem_write_data[8*k +: 8];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            misc++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Transaction-level reference: bytes, alignment, range, extension
    task automatic model(input logic w, input logic [1:0] s, input logic se,
                         input logic [31:0] a, input logic [31:0] d, output exp_t e);
        longint unsigned base;
        longint unsigned v;
        int n;
        bit bad;
        base = longint'(a) & 64'hFFFF_FFFC;
        n    = (s == 2'b11) ? 1 : (1 << s);
        bad  = (s == 2'b11) || ((longint'(a) % n) != 0) || (base + 3 >= MEMB);
        e.icyc = 0;
        if (bad) begin
            e.flt = 1'b1; e.rd = exp_rdata; e.lat = 1; e.wrc = 0; e.wro = 0;
        end else if (!w) begin
            v = 0;
            for (int i = 0; i < n; i++) v = v + (longint'(ref_mem[int'(a) + i]) << (8 * i));
            if (se && n < 4 && v >= (64'd1 << (8 * n - 1)))
                v = v + 64'h1_0000_0000 - (64'd1 << (8 * n));
            exp_rdata = v[31:0];
            e.flt = 1'b0; e.rd = exp_rdata; e.lat = 2; e.wrc = 0; e.wro = 0;
        end else begin
            for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = d[8*i +: 8];
            e.flt = 1'b0; e.rd = exp_rdata; e.wrc = 1;
            e.lat = (n == 4) ? 2 : 3;
            e.wro = (n == 4) ? 1 : 2;
        end
    endtask

    // Monitor: attribute RAM writes to the oldest transaction, check it at done
    always @(negedge clk) begin
        exp_t e;
        if (mem_write_en === 1'b1) begin
            if (q.size() == 0) begin
                vec++; misc++;
                $display("FAIL unexpected_write: got addr 0x%08h expected no write", mem_address);
            end else begin
                wr_seen++;
                wr_last = cyc - q[0].icyc;
            end
        end
        if (done === 1'b1) begin
            if (q.size() == 0) begin
                vec++; misc++;
                $display("FAIL unexpected_done: got done=1 expected none");
            end else begin
                e = q.pop_front();
                chk("fault", 32'(fault), 32'(e.flt));
                chk("rdata", rdata, e.rd);
                chk("latency", 32'(cyc - e.icyc), 32'(e.lat));
                chk("write_count", 32'(wr_seen), 32'(e.wrc));
                if (e.wrc > 0) chk("write_cycle", 32'(wr_last), 32'(e.wro));
            end
            wr_seen = 0;
            done_cnt++;
        end
    end

    task automatic wait_done(input int target, input string nm);
        int k;
        for (k = 0; k < 20 && done_cnt < target; k++) @(posedge clk);
        if (done_cnt < target) begin
            vec++; misc++;
            $display("FAIL %s_timeout: got %0d dones expected %0d", nm, done_cnt, target);
        end
    endtask

    // Issue one access; caller sits on a rising edge
    task automatic run(input logic w, input logic [1:0] s, input logic se,
                       input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        int target;
        #1;
        we = w; size = s; sign_ext = se; addr = a; wdata = d; req = 1'b1;
        model(w, s, se, a, d, e);
        e.icyc = cyc;
        q.push_back(e);
        target = done_cnt + 1;
        @(posedge clk); #1;
        req = 1'b0;
        wait_done(target, "access");
    endtask

    initial begin
        exp_t e1;
        exp_t e2;
        int   t0;
        int   bad_bytes;
        logic [1:0]  s;
        logic [31:0] a;
        int   r;

        for (int i = 0; i < MEMB; i++) init_img[i] = 8'($urandom);
        {init_img[3], init_img[2], init_img[1], init_img[0]}     = 32'hE3A00005;
        {init_img[35], init_img[34], init_img[33], init_img[32]} = 32'hE1A00000;
        for (int i = 0; i < MEMB; i++) ref_mem[i] = init_img[i];

        reset = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0;
        addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_fault", 32'(fault), 32'd0);
        chk("reset_wen", 32'(mem_write_en), 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        chk("reset_maddr", mem_address, 32'd0);
        chk("reset_mwdata", mem_write_data, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk);

        run(1'b0, 2'b10, 1'b0, 32'd0,   32'd0);
        run(1'b0, 2'b00, 1'b0, 32'd0,   32'd0);
        run(1'b0, 2'b00, 1'b1, 32'd3,   32'd0);
        run(1'b0, 2'b01, 1'b1, 32'd2,   32'd0);
        run(1'b0, 2'b01, 1'b0, 32'd2,   32'd0);
        run(1'b1, 2'b00, 1'b0, 32'd33,  32'h123456AB);
        run(1'b0, 2'b10, 1'b0, 32'd32,  32'd0);
        run(1'b0, 2'b10, 1'b0, 32'd2,   32'd0);
        run(1'b1, 2'b01, 1'b0, 32'd5,   32'hBEEF);
        run(1'b1, 2'b10, 1'b0, 32'd800, 32'hDEADBEEF);
        run(1'b0, 2'b11, 1'b0, 32'd8,   32'd0);
        run(1'b0, 2'b00, 1'b0, 32'hFFFFFFFF, 32'd0);

        // req held high: second acceptance only after the first completes
        #1;
        we = 1'b0; size = 2'b01; sign_ext = 1'b1; addr = 32'd2; wdata = '0; req = 1'b1;
        t0 = cyc;
        model(1'b0, 2'b01, 1'b1, 32'd2, 32'd0, e1); e1.icyc = t0;
        model(1'b0, 2'b01, 1'b1, 32'd2, 32'd0, e2); e2.icyc = t0 + 3;
        q.push_back(e1);
        q.push_back(e2);
        wait_done(done_cnt + 1, "held_first");
        @(posedge clk); #1;
        req = 1'b0;
        wait_done(done_cnt + 1, "held_second");

        // Reset in the WRITE cycle of a byte store aborts it
        #1;
        we = 1'b1; size = 2'b00; sign_ext = 1'b0; addr = 32'd65; wdata = 32'h5A; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("abort_wen", 32'(mem_write_en), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        exp_rdata = '0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done_after", 32'(done), 32'd0);
        chk("abort_rdata", rdata, 32'd0);
        @(posedge clk);
        run(1'b0, 2'b10, 1'b0, 32'd64, 32'd0);

        for (int n = 0; n < 200; n++) begin
            r = int'($urandom_range(0, 9));
            s = (r < 9) ? 2'(r % 3) : 2'b11;
            r = int'($urandom_range(0, 9));
            if (r < 8) begin
                a = 32'($urandom_range(0, 811));
                if ($urandom_range(0, 9) < 7) a = a & ~((32'd1 << s) - 32'd1);
            end else if (r == 8) begin
                a = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
            end else begin
                a = $urandom;
            end
            run(1'($urandom_range(0, 1)), s, 1'($urandom_range(0, 1)), a, $urandom);
        end

        repeat (3) @(posedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        bad_bytes = 0;
        for (int i = 0; i < MEMB; i++) if (ram[i] !== ref_mem[i]) bad_bytes++;
        chk("ram_image_bad_bytes", 32'(bad_bytes), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, misc);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store initiator between the CPU datapath (LDR/STR/LDRB/STRB/LDRH/STRH) and the byte-addressed RAM `memory`.
- The RAM offers only a combinational 32-bit read and a 32-bit synchronous write. This block adds sub-word extraction and sign/zero extension.
- It also does read-modify-write for byte and halfword stores, and checks alignment and range.
- Core side is a req/done handshake; RAM side drives address/write_en/write_data and consumes read_data.

Parameters:
- MEM_BYTES, 800, byte size of the attached RAM. Any access touching a byte >= MEM_BYTES faults.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req  in  1  start access; sampled only in IDLE
- we  in  1  1 = store, 0 = load
- size  in  2  00 byte, 01 halfword, 10 word; 11 faults
- sign_ext  in  1  loads only: 1 sign-extends, 0 zero-extends
- addr  in  32  byte address
- wdata  in  32  store data; byte/half use the low bits
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle completion pulse
- fault  out  1  valid with done; 1 = misaligned, out of range, or bad size
- rdata  out  32  load result; holds until the next done
- mem_address  out  32  to RAM address
- mem_write_en  out  1  to RAM write_en
- mem_write_data  out  32  to RAM write_data
- mem_read_data  in  32  from RAM read_data (combinational)

Behaviour:
- Byte lanes: for a word at aligned W = addr & ~3, byte W+k sits at data[8k+7:8k]. Lane = addr[1:0]; halfword lane pair = addr[1].
- Request latch: req && !busy in IDLE latches we, size, sign_ext, addr and wdata. req in any other state is ignored (no queueing).
- Fault conditions, checked in IDLE:
  - half with addr[0] = 1;
  - word with addr[1:0] != 0;
  - size = 11;
  - W + 3 >= MEM_BYTES, using 32-bit unsigned compare with no wrap (addr >= 0xFFFFFFFC faults).
- On fault: go IDLE -> DONE with fault = 1. No RAM write; rdata unchanged.
- States: IDLE, ACCESS, WRITE, DONE.
- ACCESS: mem_address = W.
  - Load: rdata <= extracted and extended lane; go to DONE.
  - Word store: mem_write_en = 1, mem_write_data = wdata; go to DONE.
  - Byte/half store: capture mem_read_data into a merge buffer; go to WRITE.
- WRITE: mem_address = W, mem_write_en = 1, mem_write_data = buffer with the target lane(s) replaced by wdata[7:0] or [15:0]; go to DONE.
- DONE: done = 1 for exactly one cycle, fault as latched; go to IDLE. Next req is accepted the following cycle.
- Latency from the req cycle t:
  - load: done at t+2;
  - word store: done at t+2, RAM written at the edge ending t+1;
  - sub-word store: done at t+3;
  - fault: done at t+1.
- mem_write_en is decoded from state and gated with !reset. It is never high in IDLE or DONE.
- mem_address = 0 and mem_write_data = 0 outside ACCESS/WRITE.
- Reset values: state IDLE; busy, done, fault, mem_write_en = 0; rdata, mem_address, mem_write_data = 0.
- Reset mid-operation aborts the access: no write in the reset cycle, no done pulse.
- Extension: byte sign from bit 7 of the lane, half sign from bit 15. sign_ext is ignored for word loads and all stores.

Decomposition:
- Package mem_access_pkg holds:
  - SIZE_BYTE/SIZE_HALF/SIZE_WORD constants;
  - the state encoding localparams (IDLE = 0, ACCESS = 1, WRITE = 2, DONE = 3).
- One combinational sub-module, lane_mux, provides:
  - load extract/extend (word, addr[1:0], size, sign_ext) -> 32-bit;
  - store merge (word, wdata, addr[1:0], size) -> 32-bit.
- The FSM stays in mem_access_unit.

Test Plan:
- The bench pairs the block with `memory` (NUM_OF_BYTES = 800) and resets both.
- Word load: addr 0, size 10 -> done at t+2, rdata = 0xE3A00005, fault = 0.
- Byte loads: addr 0 unsigned -> 0x00000005. Addr 3 sign_ext -> 0xFFFFFFE3. Halfword addr 2 sign_ext -> 0xFFFFE3A0; same with sign_ext = 0 -> 0x0000E3A0.
- Byte store: 0xAB to addr 33 -> mem_write_en exactly one cycle at t+2, done at t+3. Word load at 32 then returns 0xE1A0AB00.
- Faults, each giving done at t+1 with fault = 1, no mem_write_en, rdata unchanged:
  - word load at addr 2;
  - halfword store at addr 5;
  - word store at addr 800.
- Handshake and reset:
  - req held high through a load -> second access starts only after done.
  - reset asserted during WRITE of a sub-word store -> no write, no done; busy = 0 next cycle.
